// File: rtl/inst_sram_axi_bridge.sv
// Instruction-side SRAM-like to AXI read bridge.
// One outstanding single-beat read at a time; flush cancels delivery of an in-flight fetch.

module inst_sram_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    // SRAM-like fetch port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_err,
    input  logic        flush,
    output logic        busy,
    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

    state_e      state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q;
    logic        data_ok_q;
    logic        err_q;
    logic        req_hs;
    logic        r_hs;
    logic        deliver;

    // Single beat only (arlen = 0), so ID, RLAST and the EXOKAY bit carry no information.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rlast, rresp[0]};

    assign req_hs  = inst_sram_req & inst_sram_addr_ok;
    assign r_hs    = rvalid & rready;
    // A flush landing on the handshake cycle still cancels this beat.
    assign deliver = r_hs & ~drop_q & ~flush;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and drop-flag logic
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        unique case (state_q)
            StIdle:  if (req_hs)  state_d = StAr;
            StAr:    if (arready) state_d = StR;
            StR:     if (rvalid)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && flush) drop_d = 1'b1;
        if (state_d == StIdle)          drop_d = 1'b0;
    end

    // FSM-decoded outputs
    always_comb begin
        inst_sram_addr_ok = (state_q == StIdle) & inst_sram_req & ~inst_sram_wr & ~flush & ~reset;
        arvalid           = (state_q == StAr);
        rready            = (state_q == StR);
        busy              = (state_q != StIdle);
    end

    // Request latch, returned data and the registered data_ok/err pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q    <= 1'b0;
            addr_q    <= 32'h0;
            size_q    <= 2'b00;
            rdata_q   <= 32'h0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            drop_q <= drop_d;
            if (req_hs) begin
                addr_q <= inst_sram_addr;
                size_q <= inst_sram_size;
            end
            if (r_hs) rdata_q <= rdata;
            data_ok_q <= deliver;
            err_q     <= deliver & rresp[1];
        end
    end

    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_err     = err_q;
    assign inst_sram_rdata   = rdata_q;

    assign arid    = 4'd0;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'd1;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Self-checking bench for inst_sram_axi_bridge: directed scenarios plus randomized fetches
// with latency and drop expectations derived from transaction-level rules.

module tb_inst_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_err;
    logic        flush;
    logic        busy;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    inst_sram_axi_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .inst_sram_err     (inst_sram_err),
        .flush             (flush),
        .busy              (busy),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arlock            (arlock),
        .arcache           (arcache),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch with a slave that waits ar_wait cycles before arready and r_wait cycles
    // before rvalid. flush_at >= 1 pulses flush on that cycle (relative to acceptance).
    // Expected data_ok cycle is 3 + ar_wait + r_wait; ends positioned in that cycle.
    task automatic do_fetch(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input int ar_wait, input int r_wait, input logic [31:0] data,
                            input logic [1:0] resp, input int flush_at);
        int  last;
        bit  in_ar;
        bit  expect_ok;
        last = 2 + ar_wait + r_wait;
        expect_ok = (flush_at < 1);
        inst_sram_req  = 1'b1;
        inst_sram_wr   = 1'b0;
        inst_sram_addr = addr;
        inst_sram_size = size;
        flush   = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        #1;
        vectors++;
        if (inst_sram_addr_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: addr_ok=%b required 1", name, inst_sram_addr_ok);
        end
        tick();
        inst_sram_req  = 1'b0;
        inst_sram_addr = $urandom;
        inst_sram_size = 2'($urandom_range(0, 3));
        for (int c = 1; c <= last; c++) begin
            in_ar   = (c <= 1 + ar_wait);
            arready = (c == 1 + ar_wait);
            rvalid  = (c == last);
            rdata   = (c == last) ? data : $urandom;
            rresp   = (c == last) ? resp : 2'($urandom_range(0, 3));
            rlast   = (c == last);
            rid     = 4'($urandom_range(0, 15));
            flush   = (c == flush_at);
            #1;
            vectors++;
            if ({arvalid, rready, inst_sram_data_ok, busy} !== {in_ar, !in_ar, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL %s cycle %0d ctrl: arvalid/rready/data_ok/busy=%b required %b",
                         name, c, {arvalid, rready, inst_sram_data_ok, busy},
                         {in_ar, !in_ar, 1'b0, 1'b1});
            end
            if (in_ar) begin
                vectors++;
                if (araddr !== addr || arsize !== {1'b0, size}) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d ar payload: araddr=%h arsize=%0d required %h %0d",
                             name, c, araddr, arsize, addr, {1'b0, size});
                end
            end
            tick();
        end
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        flush   = 1'b0;
        #1;
        vectors++;
        if ({inst_sram_data_ok, inst_sram_err, busy} !== {expect_ok, expect_ok & resp[1], 1'b0})
        begin
            miscompares++;
            $display("FAIL %s return: data_ok/err/busy=%b required %b", name,
                     {inst_sram_data_ok, inst_sram_err, busy},
                     {expect_ok, expect_ok & resp[1], 1'b0});
        end
        if (expect_ok) begin
            vectors++;
            if (inst_sram_rdata !== data) begin
                miscompares++;
                $display("FAIL %s rdata: got %h required %h", name, inst_sram_rdata, data);
            end
        end
    endtask

    task automatic test_reset();
        inst_sram_req = 1'b1;
        #1;
        vectors++;
        if ({inst_sram_addr_ok, arvalid, rready, inst_sram_data_ok, inst_sram_err, busy} !== 6'b0
            || inst_sram_rdata !== 32'h0 || araddr !== 32'h0 || arsize !== 3'd0) begin
            miscompares++;
            $display("FAIL reset state: ctrl=%b rdata=%h araddr=%h arsize=%0d required all zero",
                     {inst_sram_addr_ok, arvalid, rready, inst_sram_data_ok, inst_sram_err, busy},
                     inst_sram_rdata, araddr, arsize);
        end
        vectors++;
        if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'd0, 8'd0, 2'd1, 2'd0, 4'd0, 3'd0})
        begin
            miscompares++;
            $display("FAIL ar constants: arid=%0d arlen=%0d arburst=%0d required 0 0 1",
                     arid, arlen, arburst);
        end
        inst_sram_req = 1'b0;
    endtask

    task automatic test_single();
        do_fetch("single", 32'hBFC0_0000, 2'd2, 0, 0, 32'h3C1D_0001, 2'b00, -1);
        // Flush alongside an already-registered pulse must not retract it.
        flush = 1'b1;
        #1;
        vectors++;
        if (inst_sram_data_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL flush on pulse: data_ok=%b required 1", inst_sram_data_ok);
        end
        flush = 1'b0;
        tick();
        vectors++;
        if (inst_sram_data_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL single pulse width: data_ok=%b required 0", inst_sram_data_ok);
        end
    endtask

    task automatic test_wait_states();
        do_fetch("wait", 32'hBFC0_0010, 2'd2, 3, 2, 32'h2408_0005, 2'b00, -1);
        tick();
        vectors++;
        if (inst_sram_data_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL wait second pulse: data_ok=%b required 0", inst_sram_data_ok);
        end
    endtask

    task automatic test_flush_r();
        do_fetch("flush_r", 32'hBFC0_0000, 2'd2, 0, 1, 32'hDEAD_BEEF, 2'b00, 2);
        do_fetch("after_flush", 32'hBFC0_0004, 2'd2, 0, 0, 32'h1234_5678, 2'b00, -1);
        tick();
    endtask

    task automatic test_flush_ar();
        do_fetch("flush_ar", 32'hBFC0_0020, 2'd2, 3, 0, 32'hCAFE_0001, 2'b00, 1);
        do_fetch("flush_hs", 32'hBFC0_0024, 2'd2, 0, 0, 32'hCAFE_0002, 2'b10, 2);
        tick();
    endtask

    task automatic test_back_to_back();
        do_fetch("b2b_first", 32'hBFC0_0100, 2'd2, 0, 0, 32'h0000_1111, 2'b00, -1);
        do_fetch("b2b_err", 32'hBFC0_0104, 2'd1, 0, 0, 32'h0000_2222, 2'b10, -1);
        do_fetch("b2b_decerr", 32'hBFC0_0108, 2'd0, 1, 0, 32'h0000_3333, 2'b11, -1);
        do_fetch("b2b_exokay", 32'hBFC0_010C, 2'd2, 0, 1, 32'h0000_4444, 2'b01, -1);
        tick();
    endtask

    task automatic test_write_and_idle_flush();
        inst_sram_req  = 1'b1;
        inst_sram_wr   = 1'b1;
        inst_sram_addr = 32'hBFC0_0200;
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++;
            if ({inst_sram_addr_ok, arvalid, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL write cycle %0d: addr_ok/arvalid/busy=%b required 000",
                         i, {inst_sram_addr_ok, arvalid, busy});
            end
            tick();
        end
        inst_sram_wr = 1'b0;
        flush        = 1'b1;
        #1;
        vectors++;
        if (inst_sram_addr_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL idle flush: addr_ok=%b required 0", inst_sram_addr_ok);
        end
        tick();
        inst_sram_req = 1'b0;
        flush         = 1'b0;
        #1;
        vectors++;
        if ({arvalid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle flush start: arvalid/busy=%b required 00", {arvalid, busy});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hBFC0_0300;
        inst_sram_size = 2'd2;
        arready        = 1'b1;
        tick();
        inst_sram_req = 1'b0;
        tick();
        // Now in R: reset together with the returning beat.
        reset  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h5555_AAAA;
        rresp  = 2'b00;
        arready = 1'b0;
        inst_sram_req = 1'b1;
        #1;
        vectors++;
        if ({rready, inst_sram_addr_ok} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset in R: rready/addr_ok=%b required 10", {rready, inst_sram_addr_ok});
        end
        tick();
        reset  = 1'b0;
        rvalid = 1'b0;
        inst_sram_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({rready, arvalid, inst_sram_data_ok, busy} !== 4'b0000) begin
                miscompares++;
                $display("FAIL after reset cycle %0d: rready/arvalid/data_ok/busy=%b required 0000",
                         i, {rready, arvalid, inst_sram_data_ok, busy});
            end
            tick();
        end
    endtask

    task automatic test_random();
        int aw, rw, fa, gap;
        for (int n = 0; n < 40; n++) begin
            aw  = $urandom_range(0, 3);
            rw  = $urandom_range(0, 3);
            fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 + aw + rw)) : -1;
            do_fetch("random", $urandom, 2'($urandom_range(0, 2)), aw, rw, $urandom,
                     2'($urandom_range(0, 3)), fa);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                #1;
                vectors++;
                if ({inst_sram_data_ok, inst_sram_err, busy} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL random gap: data_ok/err/busy=%b required 000",
                             {inst_sram_data_ok, inst_sram_err, busy});
                end
            end
        end
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        inst_sram_req  = 1'b0;
        inst_sram_wr   = 1'b0;
        inst_sram_size = 2'd0;
        inst_sram_addr = 32'h0;
        flush          = 1'b0;
        arready        = 1'b0;
        rid            = 4'd0;
        rdata          = 32'h0;
        rresp          = 2'b00;
        rlast          = 1'b0;
        rvalid         = 1'b0;
        repeat (3) tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_single();
        test_wait_states();
        test_flush_r();
        test_flush_ar();
        test_back_to_back();
        test_write_and_idle_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
